// File: rtl/tinyalu_gen2.sv
// rtl/tinyalu_gen2.sv - parametrised TinyALU: registered FSM front end with latched operands, busy and err
// Optional SUB opcode (101) is enabled by defining TINYALU_GEN2_SUB_EN; otherwise 101 is an invalid opcode.
module tinyalu_gen2 #(
   parameter int DATA_W   = 8,
   parameter int MULT_LAT = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_W-1:0]     A,
   input  logic [DATA_W-1:0]     B,
   input  logic [2:0]            op,
   input  logic                  start,
   output logic                  done,
   output logic [2*DATA_W-1:0]   result,
   output logic                  busy,
   output logic                  err
);

   localparam int RES_W = 2 * DATA_W;
   localparam int CNT_W = $clog2(MULT_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LAT - 1);

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
`ifdef TINYALU_GEN2_SUB_EN
   localparam logic [2:0] OP_SUB = 3'b101;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_MULT,
      S_FIN
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [2:0]        r_op;
   logic              r_done;
   logic              r_busy;
   logic              r_err;
   logic [RES_W-1:0]  r_result;

   logic [RES_W-1:0]  w_a_ext;
   logic [RES_W-1:0]  w_b_ext;
   logic [RES_W-1:0]  w_prod;
   logic [RES_W-1:0]  w_exec_result;
   logic              w_exec_err;

   assign w_a_ext = RES_W'(r_a);
   assign w_b_ext = RES_W'(r_b);
   assign w_prod  = w_a_ext * w_b_ext;

   // Single-cycle datapath; anything not decoded here completes as an error with a zero result.
   always_comb begin
      w_exec_result = '0;
      w_exec_err    = 1'b0;
      case (r_op)
         OP_ADD:  w_exec_result = w_a_ext + w_b_ext;
         OP_AND:  w_exec_result = w_a_ext & w_b_ext;
         OP_XOR:  w_exec_result = w_a_ext ^ w_b_ext;
`ifdef TINYALU_GEN2_SUB_EN
         OP_SUB:  w_exec_result = w_a_ext - w_b_ext;
`endif
         default: w_exec_err    = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= OP_NOP;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
         r_err    <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start && (op != OP_NOP)) begin
                  r_a    <= A;
                  r_b    <= B;
                  r_op   <= op;
                  r_busy <= 1'b1;
                  if (op == OP_MUL) begin
                     r_cnt   <= CNT_W'(1);
                     r_state <= S_MULT;
                  end else begin
                     r_state <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               r_result <= w_exec_result;
               r_err    <= w_exec_err;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= S_FIN;
            end
            S_MULT: begin
               if (r_cnt == CNT_LAST) begin
                  r_result <= w_prod;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= S_FIN;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            // FIN is not busy, but a new start is only taken once back in IDLE.
            S_FIN:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign done   = r_done;
   assign busy   = r_busy;
   assign err    = r_err;
   assign result = r_result;

endmodule

// File: tb/tb_tinyalu_gen2.sv
// tb/tb_tinyalu_gen2.sv - table-driven self-checking bench for tinyalu_gen2 (DATA_W=8, MULT_LAT=3)
module tb_tinyalu_gen2;

   logic        clk;
   logic        reset_n;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [2:0]  op;
   logic        start;
   logic        done;
   logic [15:0] result;
   logic        busy;
   logic        err;

   int checks;
   int errors;

   tinyalu_gen2 #(.DATA_W(8), .MULT_LAT(3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .A       (A),
      .B       (B),
      .op      (op),
      .start   (start),
      .done    (done),
      .result  (result),
      .busy    (busy),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [2:0]  op;
      logic [15:0] res;
      logic        e;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one operation from a negedge with the DUT idle; returns what was seen at done.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                        output logic got, output int lat, output logic [15:0] res,
                        output logic e, output logic bsy_done, output logic bsy_mid);
      got = 1'b0; lat = 0; res = '0; e = 1'b0; bsy_done = 1'b0; bsy_mid = 1'b0;
      A = a; B = b; op = o; start = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start   = 1'b0;
            bsy_mid = busy;
         end
         if (done) begin
            got = 1'b1; lat = k; res = result; e = err; bsy_done = busy;
            break;
         end
      end
   endtask

   task automatic watch_quiet(input string name, input int n);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (done || err || busy) seen = 1'b1;
      end
      check(name, {31'd0, seen}, 32'd0);
   endtask

   logic        got, e, bd, bm;
   int          lat;
   logic [15:0] res;
   logic        found;

   initial begin
      checks = 0; errors = 0;
      vecs[0]  = '{"add_ff_ff",  8'hFF, 8'hFF, 3'b001, 16'h01FE, 1'b0, 2};
      vecs[1]  = '{"and_f0_3c",  8'hF0, 8'h3C, 3'b010, 16'h0030, 1'b0, 2};
      vecs[2]  = '{"xor_f0_3c",  8'hF0, 8'h3C, 3'b011, 16'h00CC, 1'b0, 2};
      vecs[3]  = '{"mul_ff_ff",  8'hFF, 8'hFF, 3'b100, 16'hFE01, 1'b0, 3};
      vecs[4]  = '{"inv_111",    8'h12, 8'h34, 3'b111, 16'h0000, 1'b1, 2};
      vecs[5]  = '{"add_80_80",  8'h80, 8'h80, 3'b001, 16'h0100, 1'b0, 2};
      vecs[6]  = '{"inv_110",    8'hAA, 8'h55, 3'b110, 16'h0000, 1'b1, 2};
      vecs[7]  = '{"mul_10_10",  8'h10, 8'h10, 3'b100, 16'h0100, 1'b0, 3};
`ifdef TINYALU_GEN2_SUB_EN
      vecs[8]  = '{"sub_03_05",  8'h03, 8'h05, 3'b101, 16'hFFFE, 1'b0, 2};
`else
      vecs[8]  = '{"sub_03_05",  8'h03, 8'h05, 3'b101, 16'h0000, 1'b1, 2};
`endif
      vecs[9]  = '{"mul_00_ff",  8'h00, 8'hFF, 3'b100, 16'h0000, 1'b0, 3};
      vecs[10] = '{"and_a5_ff",  8'hA5, 8'hFF, 3'b010, 16'h00A5, 1'b0, 2};
      vecs[11] = '{"add_00_01",  8'h00, 8'h01, 3'b001, 16'h0001, 1'b0, 2};

      reset_n = 1'b0; start = 1'b0; A = '0; B = '0; op = '0;
      repeat (3) @(negedge clk);
      check("rst_done",   {31'd0, done}, 32'd0);
      check("rst_busy",   {31'd0, busy}, 32'd0);
      check("rst_err",    {31'd0, err},  32'd0);
      check("rst_result", {16'd0, result}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].op, got, lat, res, e, bd, bm);
         check({vecs[i].name, "_done"},  {31'd0, got}, 32'd1);
         check({vecs[i].name, "_lat"},   lat, vecs[i].lat);
         check({vecs[i].name, "_res"},   {16'd0, res}, {16'd0, vecs[i].res});
         check({vecs[i].name, "_err"},   {31'd0, e}, {31'd0, vecs[i].e});
         check({vecs[i].name, "_busy_mid"},  {31'd0, bm}, 32'd1);
         check({vecs[i].name, "_busy_done"}, {31'd0, bd}, 32'd0);
         @(negedge clk);
         check({vecs[i].name, "_done_pulse"}, {31'd0, done}, 32'd0);
         check({vecs[i].name, "_hold"}, {16'd0, result}, {16'd0, vecs[i].res});
      end

      // MUL with a second start and new operands while busy: ignored.
      A = 8'hFF; B = 8'hFF; op = 3'b100; start = 1'b1;
      @(negedge clk);
      A = 8'h01; B = 8'h01; op = 3'b001;
      @(negedge clk);
      check("mul_busy_pre", {31'd0, done}, 32'd0);
      start = 1'b0;
      @(negedge clk);
      check("mul_busy_done", {31'd0, done}, 32'd1);
      check("mul_busy_res", {16'd0, result}, 32'h0000FE01);
      watch_quiet("mul_busy_no_second", 6);

      // Back-to-back: XOR requested on the AND done cycle.
      do_op(8'hF0, 8'h3C, 3'b010, got, lat, res, e, bd, bm);
      check("b2b_and_res", {16'd0, res}, 32'h00000030);
      A = 8'hF0; B = 8'h3C; op = 3'b011; start = 1'b1;
      @(negedge clk);
      check("b2b_idle_hold", {16'd0, result}, 32'h00000030);
      check("b2b_idle_done", {31'd0, done}, 32'd0);
      found = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            found = 1'b1;
            break;
         end
      end
      check("b2b_xor_done", {31'd0, found}, 32'd1);
      check("b2b_xor_res", {16'd0, result}, 32'h000000CC);
      @(negedge clk);

      // NOP start: nothing happens.
      A = 8'h12; B = 8'h34; op = 3'b000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("nop_busy", {31'd0, busy}, 32'd0);
      watch_quiet("nop_quiet", 5);

      // Reset asserted the cycle after a MUL is accepted.
      A = 8'hFF; B = 8'hFF; op = 3'b100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("rmid_busy", {31'd0, busy}, 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("rmid_busy0", {31'd0, busy}, 32'd0);
      check("rmid_res0", {16'd0, result}, 32'd0);
      watch_quiet("rmid_quiet", 6);
      do_op(8'h01, 8'h01, 3'b001, got, lat, res, e, bd, bm);
      check("rmid_add_done", {31'd0, got}, 32'd1);
      check("rmid_add_res", {16'd0, res}, 32'h00000002);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
